pb_key_encoder: RTL

- Upstream front end of the push-button calculator datapath, between the 16 raw active-low board buttons and the operand/operator display logic.
- Synchronises and debounces `pb`, then detects single-key press events and encodes each one to a 4-bit key code.
- Queues key codes in a small FIFO with a valid/ready handshake, so the consumer never misses or double-counts a press.
- Replaces ad-hoc edge detection on a divided clock with a single-clock, enable-based design.

---
 rtl/pb_key_encoder.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pb_key_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : pb_key_encoder
//  Purpose  : Front end of the push-button calculator datapath. Synchronises
//             and debounces 16 raw active-low buttons, turns each clean
//             single-key press into a 4-bit key code and queues the codes
//             in a small FIFO behind a valid/ready handshake.
//  Ports    : clock_50m    - system clock (rising edge)
//             reset_n      - asynchronous active-low reset
//             pb[15:0]     - raw buttons, active-low, asynchronous
//             key_valid    - FIFO head holds an event
//             key_ready    - consumer accepts the head (pop on valid&&ready)
//             key_code     - code of the FIFO head (0 when empty)
//             key_is_digit - key_code <= 9
//             fifo_count   - number of queued events
//             multi_err    - 1-cycle pulse: debounced value became multi-key
//             overflow     - 1-cycle pulse: event dropped, FIFO full
//  Revision : 1.0 - initial release
// ============================================================================
module pb_key_encoder #(
  parameter int TICK_W     = 18,
  parameter int DEB_CNT    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock_50m,
  input  logic                          reset_n,
  input  logic [15:0]                   pb,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [3:0]                    key_code,
  output logic                          key_is_digit,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          multi_err,
  output logic                          overflow
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          PW      = AW + 1;
  localparam logic [3:0]  DEB_MAX = 4'(DEB_CNT);

  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_HELD = 1'b1;

  // --------------------------------------------------------------------------
  // Input synchroniser. Inversion happens before the first flop so that
  // reset value 0 means "nothing pressed".
  // --------------------------------------------------------------------------
  logic [15:0] sync1_q;
  logic [15:0] npb_s_q;

  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      npb_s_q <= '0;
    end else begin
      sync1_q <= ~pb;
      npb_s_q <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Free-running prescaler; tick marks the all-ones cycle.
  // --------------------------------------------------------------------------
  logic [TICK_W-1:0] presc_q;
  logic              w_tick;

  assign w_tick = &presc_q;

  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + TICK_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Debounce. A new sample restarts the run length at 1; the debounced value
  // follows once the run length reaches DEB_MAX, i.e. the same value has been
  // seen on DEB_CNT consecutive ticks. deb_upd is registered alongside the
  // debounced value so downstream logic sees both in the same cycle.
  // --------------------------------------------------------------------------
  logic [15:0] last_q,  last_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [15:0] deb_q,   deb_d;
  logic        upd_q,   upd_d;

  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    upd_d  = 1'b0;
    if (w_tick) begin
      if (npb_s_q != last_q) begin
        last_d = npb_s_q;
        cnt_d  = 4'd1;
      end else begin
        if (cnt_q < DEB_MAX) begin
          cnt_d = cnt_q + 4'd1;
        end
        if ((cnt_d == DEB_MAX) && (last_q != deb_q)) begin
          deb_d = last_q;
          upd_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= '0;
      cnt_q  <= '0;
      deb_q  <= '0;
      upd_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      upd_q  <= upd_d;
    end
  end

  // --------------------------------------------------------------------------
  // Key encoder. Every one-hot pattern has a code, so the code is only used
  // when the pattern is one-hot.
  // --------------------------------------------------------------------------
  logic [3:0] w_enc_code;
  logic       w_nonzero;
  logic       w_onehot;

  assign w_nonzero = (deb_q != 16'h0000);
  assign w_onehot  = w_nonzero && ((deb_q & (deb_q - 16'd1)) == 16'h0000);

  always_comb begin
    w_enc_code = 4'd0;
    case (deb_q)
      16'h2000: w_enc_code = 4'd0;
      16'h0001: w_enc_code = 4'd1;
      16'h0002: w_enc_code = 4'd2;
      16'h0004: w_enc_code = 4'd3;
      16'h0010: w_enc_code = 4'd4;
      16'h0020: w_enc_code = 4'd5;
      16'h0040: w_enc_code = 4'd6;
      16'h0100: w_enc_code = 4'd7;
      16'h0200: w_enc_code = 4'd8;
      16'h0400: w_enc_code = 4'd9;
      16'h0008: w_enc_code = 4'd10;
      16'h0080: w_enc_code = 4'd11;
      16'h0800: w_enc_code = 4'd12;
      16'h8000: w_enc_code = 4'd13;
      16'h4000: w_enc_code = 4'd14;
      16'h1000: w_enc_code = 4'd15;
      default:  w_enc_code = 4'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Press FSM. HELD absorbs roll-overs: only a full release re-arms it.
  // --------------------------------------------------------------------------
  logic [0:0] state_q, state_d;
  logic       w_push;
  logic       w_multi;

  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (upd_q && w_nonzero)  state_d = ST_HELD;
      ST_HELD: if (upd_q && !w_nonzero) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_push  = 1'b0;
    w_multi = 1'b0;
    if ((state_q == ST_IDLE) && upd_q) begin
      w_push  = w_onehot;
      w_multi = w_nonzero && !w_onehot;
    end
  end

  assign multi_err = w_multi;

  // --------------------------------------------------------------------------
  // Event FIFO. Pointers carry one extra wrap bit to tell full from empty.
  // When full, a simultaneous pop frees the slot being written, so the push
  // is accepted.
  // --------------------------------------------------------------------------
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr_en;

  assign w_empty = (wr_q == rd_q);
  assign w_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign w_pop   = !w_empty && key_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign overflow = w_push && w_full && !w_pop;

  always_ff @(posedge clock_50m) begin
    if (w_wr_en) begin
      mem_q[wr_q[AW-1:0]] <= w_enc_code;
    end
  end

  always_ff @(posedge clock_50m or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (w_wr_en) begin
        wr_q <= wr_q + PW'(1);
      end
      if (w_pop) begin
        rd_q <= rd_q + PW'(1);
      end
    end
  end

  // Head is forced to 0 when empty so stale storage never shows on the port.
  assign key_valid    = !w_empty;
  assign key_code     = w_empty ? 4'd0 : mem_q[rd_q[AW-1:0]];
  assign key_is_digit = (key_code <= 4'd9);
  assign fifo_count   = wr_q - rd_q;

endmodule
`default_nettype wire
